key_schedule_sequencer: RTL and testbench

Sequential AES-128 key expansion controller that turns a 128-bit cipher key into the 11 round keys (rounds 0–10), one round key per accepted handshake. It instantiates `g_func_key_expansion` for the per-round g() step and streams round keys to the round datapath over a valid/ready interface. It also retains all 11 keys in a local key store so later blocks can re-read them by round index without re-expanding.

---
 rtl/key_schedule_sequencer.sv | 170 +++++++++++++++++
 tb/tb_key_schedule_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_sequencer.sv
// AES-128 key expansion sequencer: streams round keys 0..10 over valid/ready and keeps
// all 11 keys in a readable store. One round key per accepted handshake, g() used combinationally.

module g_func_key_expansion (
    input  logic [31:0] key_word,
    input  logic [3:0]  count,
    output logic [31:0] g_out
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as the GF(2^8) inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [31:0] rot;

    always_comb begin
        rot   = {key_word[23:0], key_word[31:24]};
        g_out = {sbox_byte(rot[31:24]), sbox_byte(rot[23:16]),
                 sbox_byte(rot[15:8]),  sbox_byte(rot[7:0])} ^ {rcon(count), 24'h000000};
    end
endmodule

module key_schedule_sequencer (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [127:0] cipher_key,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done,
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_data,
    output logic         store_valid
);
    typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

    state_t       state;
    state_t       state_nxt;
    logic         load_key;
    logic         advance;
    logic         last_accept;
    logic [3:0]   g_count;
    logic [3:0]   round_inc;
    logic [31:0]  g_out;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_key;
    logic [127:0] store [0:10];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        load_key    = 1'b0;
        advance     = 1'b0;
        last_accept = 1'b0;
        rk_valid    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_key  = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                rk_valid = 1'b1;
                busy     = 1'b1;
                if (rk_ready) begin
                    if (rk_round == 4'd10) begin
                        last_accept = 1'b1;
                        state_nxt   = FINISH;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Clamp keeps the Rcon index in 0..9 even while round 10 is on the bus
    assign g_count   = (rk_round > 4'd9) ? 4'd9 : rk_round;
    assign round_inc = rk_round + 4'd1;

    g_func_key_expansion u_g (
        .key_word (rk_data[31:0]),
        .count    (g_count),
        .g_out    (g_out)
    );

    assign n0       = rk_data[127:96] ^ g_out;
    assign n1       = rk_data[95:64]  ^ n0;
    assign n2       = rk_data[63:32]  ^ n1;
    assign n3       = rk_data[31:0]   ^ n2;
    assign next_key = {n0, n1, n2, n3};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rk_data     <= '0;
            rk_round    <= 4'd0;
            store_valid <= 1'b0;
            for (int i = 0; i < 11; i++) store[i] <= '0;
        end else begin
            if (load_key) begin
                rk_data     <= cipher_key;
                rk_round    <= 4'd0;
                store[0]    <= cipher_key;
                store_valid <= 1'b0;
            end else if (advance) begin
                rk_data          <= next_key;
                rk_round         <= round_inc;
                store[round_inc] <= next_key;
            end
            if (last_accept) store_valid <= 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_addr <= 4'd10) rd_data = store[rd_addr];
    end
endmodule

// File: tb/tb_key_schedule_sequencer.sv
// Bench for key_schedule_sequencer: FIPS-197 style word expansion model with a table S-box,
// randomized backpressure and keys, directed checks for store, ignored start and mid-run reset.

module tb_key_schedule_sequencer;
    logic         clk = 1'b0;
    logic         n_rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] cipher_key = '0;
    logic         rk_ready = 1'b0;
    logic [3:0]   rd_addr = '0;
    logic         rk_valid, busy, done, store_valid;
    logic [127:0] rk_data, rd_data;
    logic [3:0]   rk_round;

    int tests = 0;
    int fails = 0;
    logic [127:0] exp_keys [0:10];

    localparam logic [127:0] NIST_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    always #5 clk = ~clk;

    key_schedule_sequencer dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .cipher_key  (cipher_key),
        .rk_ready    (rk_ready),
        .rk_valid    (rk_valid),
        .rk_data     (rk_data),
        .rk_round    (rk_round),
        .busy        (busy),
        .done        (done),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .store_valid (store_valid)
    );

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[2047 - 8*int'(x) -: 8];
    endfunction

    task automatic compute_expected(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // mode 0: ready always high; 1: random stalls plus 3 stalls at round 4; 2: stray start during round 5
    task automatic run_stream(input logic [127:0] key, input int mode, input logic [127:0] alt_key);
        int   idx, stalls, stall4, c;
        logic rdy;
        bit   pulsed, fin;
        compute_expected(key);
        @(negedge clk);
        start = 1'b1; cipher_key = key; rk_ready = 1'b1;
        idx = 0; stalls = 0; stall4 = 0; pulsed = 0; fin = 0;
        for (c = 1; c <= 200 && !fin; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1) chk("store_valid_clear", 128'(store_valid), '0);
            if (rk_valid) begin
                if (idx <= 10) begin
                    chk("rk_round", 128'(rk_round), 128'(idx));
                    chk("rk_data", rk_data, exp_keys[idx]);
                end else begin
                    chk("extra_round", 128'(rk_valid), '0);
                end
                chk("busy_stream", 128'(busy), 128'(1));
                rdy = 1'b1;
                if (mode == 1) begin
                    if (idx == 4 && stall4 < 3) begin
                        rdy = 1'b0;
                        stall4++;
                    end else if (idx != 4) begin
                        rdy = ($urandom_range(0, 3) != 0);
                    end
                end
                if (mode == 2 && idx == 5 && !pulsed) begin
                    start = 1'b1; cipher_key = alt_key; pulsed = 1;
                end
                rk_ready = rdy;
                if (rdy) idx++;
                else     stalls++;
            end else begin
                chk("done_pulse", 128'(done), 128'(1));
                chk("busy_finish", 128'(busy), '0);
                chk("rounds_seen", 128'(idx), 128'(11));
                chk("done_cycle", 128'(c), 128'(12 + stalls));
                chk("store_valid_set", 128'(store_valid), 128'(1));
                fin = 1;
                start = 1'b1; cipher_key = ~key;
            end
        end
        if (!fin) chk("stream_timeout", 128'(fin), 128'(1));
        @(negedge clk);
        start = 1'b0;
        chk("idle_valid", 128'(rk_valid), '0);
        chk("idle_busy", 128'(busy), '0);
        chk("idle_done", 128'(done), '0);
        chk("idle_store_valid", 128'(store_valid), 128'(1));
        chk("idle_round_hold", 128'(rk_round), 128'(10));
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            chk("store_rd", rd_data, (a <= 10) ? exp_keys[a] : '0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #2 n_rst = 1'b0;
        #2;
        chk("rst_valid", 128'(rk_valid), '0);
        chk("rst_busy", 128'(busy), '0);
        chk("rst_done", 128'(done), '0);
        chk("rst_store_valid", 128'(store_valid), '0);
        chk("rst_data", rk_data, '0);
        chk("rst_round", 128'(rk_round), '0);
        rd_addr = 4'd10;
        #1 chk("rst_store10", rd_data, '0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        run_stream(NIST_KEY, 0, '0);
        rd_addr = 4'd1;
        #1 chk("nist_round1", rd_data, 128'ha0fafe1788542cb123a339392a6c7605);
        rd_addr = 4'd10;
        #1 chk("nist_round10", rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run_stream(NIST_KEY, 1, '0);

        run_stream(NIST_KEY, 2, SEQ_KEY);
        run_stream(SEQ_KEY, 0, '0);
        rd_addr = 4'd10;
        #1 chk("seq_round10", rd_data, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        repeat (3) run_stream({$urandom, $urandom, $urandom, $urandom}, 1, '0);

        compute_expected(NIST_KEY);
        @(negedge clk);
        start = 1'b1; cipher_key = NIST_KEY; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_reset_round", 128'(rk_round), 128'(7));
        #2 n_rst = 1'b0;
        #1;
        chk("arst_valid", 128'(rk_valid), '0);
        chk("arst_busy", 128'(busy), '0);
        chk("arst_done", 128'(done), '0);
        chk("arst_store_valid", 128'(store_valid), '0);
        chk("arst_data", rk_data, '0);
        chk("arst_round", 128'(rk_round), '0);
        for (int a = 0; a < 11; a++) begin
            rd_addr = 4'(a);
            #1 chk("arst_store", rd_data, '0);
        end
        @(negedge clk);
        n_rst = 1'b1;

        run_stream(NIST_KEY, 0, '0);
        rd_addr = 4'd1;
        #1 chk("rerun_round1", rd_data, 128'ha0fafe1788542cb123a339392a6c7605);
        rd_addr = 4'd10;
        #1 chk("rerun_round10", rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
